// File: rtl/blackjack_pkg.sv
// Shared blackjack definitions: result codes, chip-bank state encodings, chip-value width.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package blackjack_pkg;

    localparam int CHIP_W = 16;

    typedef enum logic [2:0] {
        RES_LOSE      = 3'd0,
        RES_PUSH      = 3'd1,
        RES_WIN       = 3'd2,
        RES_BLACKJACK = 3'd3
    } result_t;

    typedef enum logic [1:0] {
        ST_BET    = 2'd0,
        ST_HAND   = 2'd1,
        ST_SETTLE = 2'd2,
        ST_BROKE  = 2'd3
    } bank_state_t;

endpackage

// File: rtl/bank_payout_calc.sv
// Payout for a finished hand: credit returned to the balance for a given stake and result code.
// Latency: combinational.
// Backpressure: none.
module bank_payout_calc
    import blackjack_pkg::*;
(
    input  logic [CHIP_W-1:0] stake,
    input  logic [2:0]        result,
    output logic [CHIP_W:0]   credit
);

    logic [CHIP_W:0] stake_x2;
    logic [CHIP_W:0] stake_half;

    assign stake_x2   = {stake, 1'b0};
    assign stake_half = {2'b00, stake[CHIP_W-1:1]};

    always_comb begin
        credit = {1'b0, stake};
        case (result)
            RES_LOSE:      credit = '0;
            RES_WIN:       credit = stake_x2;
            RES_BLACKJACK: credit = stake_x2 + stake_half;
            default:       credit = {1'b0, stake};   // PUSH and the unused codes 4-7
        endcase
    end

endmodule

// File: rtl/chip_bank.sv
// Player chip bank: bet selection, stake lock on deal, settlement; doubling under CHIP_BANK_DOUBLE_EN.
// Latency: deal_req -> balance 1 cycle; result_valid -> balance 2 cycles.
// Backpressure: none; pulses arriving in a state that cannot use them are dropped.
module chip_bank
    import blackjack_pkg::*;
#(
    parameter int START_BALANCE = 100,
    parameter int MAX_BALANCE   = 9999,
    parameter int MIN_BET       = 5,
    parameter int BET_STEP      = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bet_up,
    input  logic              bet_down,
    input  logic              deal_req,
    input  logic              double_req,
    input  logic              result_valid,
    input  logic [2:0]        result,
    output logic [CHIP_W-1:0] balance,
    output logic [CHIP_W-1:0] bet,
    output logic              deal_ok,
    output logic              busy,
    output logic              broke
);

    typedef logic [CHIP_W+1:0] wide_t;

    localparam wide_t MIN_W  = wide_t'(MIN_BET);
    localparam wide_t MAX_W  = wide_t'(MAX_BALANCE);
    localparam wide_t STEP_W = wide_t'(BET_STEP);
    localparam logic [CHIP_W-1:0] MIN_BET_V = MIN_BET[CHIP_W-1:0];
    localparam logic [CHIP_W-1:0] START_V   = START_BALANCE[CHIP_W-1:0];

    bank_state_t       state, state_nxt;
    logic [CHIP_W-1:0] balance_q, bet_q, stake_q;
    logic [2:0]        res_q;
    logic              deal_ok_q;
    logic [CHIP_W:0]   credit;
    wide_t             settle_sum, settle_bal, bet_up_v;
    logic              deal_acc, settle_low, up_ok, dn_ok;

    bank_payout_calc u_payout (
        .stake  (stake_q),
        .result (res_q),
        .credit (credit)
    );

    assign deal_acc   = (state == ST_BET) && deal_req &&
                        (wide_t'(bet_q) >= MIN_W) && (bet_q <= balance_q);
    // 18-bit sum: 9999 + 2.5 * 9999 cannot wrap before the ceiling is applied
    assign settle_sum = wide_t'(balance_q) + wide_t'(credit);
    assign settle_bal = (settle_sum > MAX_W) ? MAX_W : settle_sum;
    assign settle_low = settle_bal < MIN_W;
    assign bet_up_v   = wide_t'(bet_q) + STEP_W;
    assign up_ok      = (bet_up_v <= wide_t'(balance_q)) && (bet_up_v <= MAX_W);
    assign dn_ok      = wide_t'(bet_q) >= (MIN_W + STEP_W);

`ifdef CHIP_BANK_DOUBLE_EN
    logic doubled_q;
    logic dbl_acc;
    // result_valid wins: the hand settles on the undoubled stake
    assign dbl_acc = (state == ST_HAND) && double_req && !result_valid &&
                     !doubled_q && (balance_q >= stake_q);
`else
    logic unused_double;
    assign unused_double = double_req;
`endif

    always_ff @(posedge clk) begin
        if (rst) state <= ST_BET;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_BET:    if (deal_acc) state_nxt = ST_HAND;
            ST_HAND:   if (result_valid) state_nxt = ST_SETTLE;
            ST_SETTLE: state_nxt = settle_low ? ST_BROKE : ST_BET;
            default:   state_nxt = ST_BROKE;
        endcase
    end

    always_comb begin
        busy    = (state == ST_HAND) || (state == ST_SETTLE);
        broke   = (state == ST_BROKE);
        bet     = busy ? stake_q : bet_q;
        balance = balance_q;
        deal_ok = deal_ok_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            balance_q <= START_V;
            bet_q     <= MIN_BET_V;
            stake_q   <= '0;
            res_q     <= '0;
            deal_ok_q <= 1'b0;
`ifdef CHIP_BANK_DOUBLE_EN
            doubled_q <= 1'b0;
`endif
        end else begin
            deal_ok_q <= 1'b0;
            case (state)
                ST_BET: begin
                    if (deal_acc) begin
                        stake_q   <= bet_q;
                        balance_q <= balance_q - bet_q;
                        deal_ok_q <= 1'b1;
`ifdef CHIP_BANK_DOUBLE_EN
                        doubled_q <= 1'b0;
`endif
                    end else if (bet_up && !bet_down && up_ok) begin
                        bet_q <= bet_up_v[CHIP_W-1:0];
                    end else if (bet_down && !bet_up && dn_ok) begin
                        bet_q <= bet_q - STEP_W[CHIP_W-1:0];
                    end
                end
                ST_HAND: begin
                    if (result_valid) res_q <= result;
`ifdef CHIP_BANK_DOUBLE_EN
                    if (dbl_acc) begin
                        balance_q <= balance_q - stake_q;
                        stake_q   <= {stake_q[CHIP_W-2:0], 1'b0};
                        doubled_q <= 1'b1;
                    end
`endif
                end
                ST_SETTLE: begin
                    balance_q <= settle_bal[CHIP_W-1:0];
                    stake_q   <= '0;
                    if (!settle_low && (wide_t'(bet_q) > settle_bal)) bet_q <= MIN_BET_V;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_chip_bank.sv
// Bench for chip_bank: three instances (start balance 100, 9990, 5) against a hand-level model.
// Build with CHIP_BANK_DOUBLE_EN defined to exercise doubling.
module tb_chip_bank;
    import blackjack_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic bet_up = 0, bet_down = 0, deal_req = 0, double_req = 0, result_valid = 0;
    logic [2:0] result = '0;
    logic [15:0] bal_o [3];
    logic [15:0] bet_o [3];
    logic        dok_o [3];
    logic        busy_o [3];
    logic        broke_o [3];

    int checks = 0;
    int failures = 0;

`ifdef CHIP_BANK_DOUBLE_EN
    localparam bit DBL = 1'b1;
`else
    localparam bit DBL = 1'b0;
`endif

    always #5 clk = ~clk;

    chip_bank #(.START_BALANCE(100)) u_a (
        .clk(clk), .rst(rst), .bet_up(bet_up), .bet_down(bet_down), .deal_req(deal_req),
        .double_req(double_req), .result_valid(result_valid), .result(result),
        .balance(bal_o[0]), .bet(bet_o[0]), .deal_ok(dok_o[0]), .busy(busy_o[0]), .broke(broke_o[0]));
    chip_bank #(.START_BALANCE(9990)) u_b (
        .clk(clk), .rst(rst), .bet_up(bet_up), .bet_down(bet_down), .deal_req(deal_req),
        .double_req(double_req), .result_valid(result_valid), .result(result),
        .balance(bal_o[1]), .bet(bet_o[1]), .deal_ok(dok_o[1]), .busy(busy_o[1]), .broke(broke_o[1]));
    chip_bank #(.START_BALANCE(5)) u_c (
        .clk(clk), .rst(rst), .bet_up(bet_up), .bet_down(bet_down), .deal_req(deal_req),
        .double_req(double_req), .result_valid(result_valid), .result(result),
        .balance(bal_o[2]), .bet(bet_o[2]), .deal_ok(dok_o[2]), .busy(busy_o[2]), .broke(broke_o[2]));

    // Hand-level model: where the player is in the game and what money is on the table
    localparam int P_IDLE = 0, P_PLAYING = 1, P_PAYING = 2, P_BANKRUPT = 3;
    int start_bal [3] = '{100, 9990, 5};
    int m_bal [3], m_bet [3], m_stake [3], m_phase [3], m_res [3];
    bit m_dok [3], m_doubled [3];

    function automatic int payout(int stake, int res);
        case (res)
            0: return 0;
            2: return 2 * stake;
            3: return 2 * stake + stake / 2;
            default: return stake;
        endcase
    endfunction

    task automatic model_step(int i);
        int nb;
        if (rst) begin
            m_bal[i] = start_bal[i]; m_bet[i] = 5; m_stake[i] = 0;
            m_phase[i] = P_IDLE; m_dok[i] = 0; m_doubled[i] = 0; m_res[i] = 0;
            return;
        end
        m_dok[i] = 0;
        case (m_phase[i])
            P_IDLE: begin
                if (deal_req && m_bet[i] <= m_bal[i]) begin
                    m_stake[i] = m_bet[i]; m_bal[i] -= m_bet[i];
                    m_dok[i] = 1; m_doubled[i] = 0; m_phase[i] = P_PLAYING;
                end else if (bet_up && !bet_down) begin
                    if (m_bet[i] + 5 <= m_bal[i] && m_bet[i] + 5 <= 9999) m_bet[i] += 5;
                end else if (bet_down && !bet_up) begin
                    if (m_bet[i] - 5 >= 5) m_bet[i] -= 5;
                end
            end
            P_PLAYING: begin
                if (result_valid) begin
                    m_res[i] = int'(result); m_phase[i] = P_PAYING;
                end else if (DBL && double_req && !m_doubled[i] && m_bal[i] >= m_stake[i]) begin
                    m_bal[i] -= m_stake[i]; m_stake[i] *= 2; m_doubled[i] = 1;
                end
            end
            P_PAYING: begin
                nb = m_bal[i] + payout(m_stake[i], m_res[i]);
                if (nb > 9999) nb = 9999;
                m_bal[i] = nb; m_stake[i] = 0;
                if (nb < 5) m_phase[i] = P_BANKRUPT;
                else begin
                    m_phase[i] = P_IDLE;
                    if (m_bet[i] > nb) m_bet[i] = 5;
                end
            end
            default: ;
        endcase
    endtask

    // One clock: model follows the edge, inputs drop at the falling edge, then every instance is compared
    task automatic tick();
        bit      in_hand;
        int      exp_bet;
        @(posedge clk);
        for (int i = 0; i < 3; i++) model_step(i);
        @(negedge clk);
        bet_up = 0; bet_down = 0; deal_req = 0; double_req = 0; result_valid = 0;
        for (int i = 0; i < 3; i++) begin
            in_hand = (m_phase[i] == P_PLAYING) || (m_phase[i] == P_PAYING);
            exp_bet = in_hand ? m_stake[i] : m_bet[i];
            checks++;
            if (int'(bal_o[i]) !== m_bal[i] || int'(bet_o[i]) !== exp_bet || dok_o[i] !== m_dok[i] ||
                busy_o[i] !== in_hand || broke_o[i] !== (m_phase[i] == P_BANKRUPT)) begin
                failures++;
                $display("FAIL model[%0d] t=%0t got bal=%0d bet=%0d dok=%b busy=%b broke=%b want bal=%0d bet=%0d dok=%b busy=%b broke=%b",
                         i, $time, bal_o[i], bet_o[i], dok_o[i], busy_o[i], broke_o[i],
                         m_bal[i], exp_bet, m_dok[i], in_hand, m_phase[i] == P_BANKRUPT);
            end
        end
    endtask

    task automatic do_reset();
        rst = 1; tick(); rst = 0;
    endtask

    task automatic pulse_up(int n);
        for (int k = 0; k < n; k++) begin bet_up = 1; tick(); end
    endtask

    task automatic finish_hand(logic [2:0] r);
        result_valid = 1; result = r; tick(); tick();
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (int'(bal_o[i]) !== start_bal[i] || bet_o[i] !== 16'd5 || dok_o[i] !== 0 ||
                busy_o[i] !== 0 || broke_o[i] !== 0) begin
                failures++;
                $display("FAIL reset[%0d] got bal=%0d bet=%0d dok=%b busy=%b broke=%b want bal=%0d bet=5 0 0 0",
                         i, bal_o[i], bet_o[i], dok_o[i], busy_o[i], broke_o[i], start_bal[i]);
            end
        end
    endtask

    task automatic test_defaults();
        do_reset(); pulse_up(3);
        deal_req = 1; tick();
        checks++;
        if (bet_o[0] !== 16'd20 || bal_o[0] !== 16'd80 || dok_o[0] !== 1 || busy_o[0] !== 1) begin
            failures++;
            $display("FAIL deal got bet=%0d bal=%0d dok=%b busy=%b want 20 80 1 1", bet_o[0], bal_o[0], dok_o[0], busy_o[0]);
        end
        tick();
        checks++;
        if (dok_o[0] !== 0) begin failures++; $display("FAIL deal_ok_pulse got %b want 0", dok_o[0]); end
        finish_hand(RES_WIN);
        checks++;
        if (bal_o[0] !== 16'd120 || busy_o[0] !== 0) begin
            failures++; $display("FAIL win got bal=%0d busy=%b want 120 0", bal_o[0], busy_o[0]);
        end
    endtask

    task automatic test_blackjack();
        do_reset(); pulse_up(2);
        deal_req = 1; tick();
        checks++;
        if (bal_o[0] !== 16'd85) begin failures++; $display("FAIL bj_deal got %0d want 85", bal_o[0]); end
        finish_hand(RES_BLACKJACK);
        checks++;
        if (bal_o[0] !== 16'd122) begin failures++; $display("FAIL blackjack got %0d want 122", bal_o[0]); end
    endtask

    task automatic test_saturation();
        do_reset(); pulse_up(3);
        deal_req = 1; tick();
        checks++;
        if (bal_o[1] !== 16'd9970) begin failures++; $display("FAIL sat_deal got %0d want 9970", bal_o[1]); end
        finish_hand(RES_WIN);
        checks++;
        if (bal_o[1] !== 16'd9999) begin failures++; $display("FAIL saturate got %0d want 9999", bal_o[1]); end
    endtask

    task automatic test_broke();
        do_reset();
        deal_req = 1; tick();
        finish_hand(RES_LOSE);
        checks++;
        if (broke_o[2] !== 1 || bal_o[2] !== 16'd0) begin
            failures++; $display("FAIL broke got broke=%b bal=%0d want 1 0", broke_o[2], bal_o[2]);
        end
        bet_up = 1; tick(); deal_req = 1; tick(); result_valid = 1; result = RES_WIN; tick(); tick();
        checks++;
        if (broke_o[2] !== 1 || bal_o[2] !== 16'd0 || bet_o[2] !== 16'd5 || busy_o[2] !== 0) begin
            failures++; $display("FAIL broke_hold got broke=%b bal=%0d bet=%0d busy=%b want 1 0 5 0",
                                 broke_o[2], bal_o[2], bet_o[2], busy_o[2]);
        end
    endtask

    task automatic test_guards();
        do_reset();
        deal_req = 1; tick();
        finish_hand(RES_WIN);       // instance c now holds 10
        pulse_up(3);
        checks++;
        if (bet_o[2] !== 16'd10 || bal_o[2] !== 16'd10) begin
            failures++; $display("FAIL bet_ceiling got bet=%0d bal=%0d want 10 10", bet_o[2], bal_o[2]);
        end
        bet_down = 1; tick(); bet_down = 1; tick();
        checks++;
        if (bet_o[2] !== 16'd5) begin failures++; $display("FAIL bet_floor got %0d want 5", bet_o[2]); end
        bet_up = 1; bet_down = 1; tick();
        checks++;
        if (bet_o[2] !== 16'd5) begin failures++; $display("FAIL up_down got %0d want 5", bet_o[2]); end
        result_valid = 1; result = RES_WIN; tick(); tick();
        checks++;
        if (bal_o[2] !== 16'd10 || busy_o[2] !== 0) begin
            failures++; $display("FAIL idle_result got bal=%0d busy=%b want 10 0", bal_o[2], busy_o[2]);
        end
    endtask

    task automatic test_double();
        do_reset(); pulse_up(3);
        deal_req = 1; tick();
        double_req = 1; tick();
        checks++;
        if (bal_o[0] !== (DBL ? 16'd60 : 16'd80) || bet_o[0] !== (DBL ? 16'd40 : 16'd20)) begin
            failures++; $display("FAIL double got bal=%0d bet=%0d want %0d %0d", bal_o[0], bet_o[0],
                                 DBL ? 60 : 80, DBL ? 40 : 20);
        end
        double_req = 1; tick();
        finish_hand(RES_WIN);
        checks++;
        if (bal_o[0] !== (DBL ? 16'd140 : 16'd120)) begin
            failures++; $display("FAIL double_win got %0d want %0d", bal_o[0], DBL ? 140 : 120);
        end
        // double and result together: settles on the undoubled stake
        deal_req = 1; tick();
        double_req = 1; result_valid = 1; result = RES_WIN; tick(); tick();
        checks++;
        if (bal_o[0] !== (DBL ? 16'd160 : 16'd140)) begin
            failures++; $display("FAIL double_vs_result got %0d want %0d", bal_o[0], DBL ? 160 : 140);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            bet_up       = ($urandom_range(0, 3) == 0);
            bet_down     = ($urandom_range(0, 5) == 0);
            deal_req     = ($urandom_range(0, 4) == 0);
            double_req   = ($urandom_range(0, 3) == 0);
            result_valid = ($urandom_range(0, 3) == 0);
            result       = 3'($urandom_range(0, 7));
            rst          = ($urandom_range(0, 150) == 0);
            tick();
            rst = 0;
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_defaults();
        test_blackjack();
        test_saturation();
        test_broke();
        test_guards();
        test_double();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
